if_id_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the pipelined RV32I core. It generates the PC and runs the request/acknowledge handshake with instruction memory. It holds the fetched instruction across decode stalls and flushes on control-flow redirects. It presents the ID stage with the registered instruction, its PC and a pre-decoded immediate-format select, which feed the immediate generator directly.

---
 rtl/if_id_stage.sv | 122 ++++++++++++
 tb/tb_if_id_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// Instruction fetch and IF/ID pipeline register for the RV32I core: PC generation,
// imem request/ack handshake, one-entry skid buffer for decode stalls, redirect flush.
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall_id,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [2:0]  id_ImmSel
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] DROP  = 2'd2;

    localparam logic [2:0] NOP_SEL = 3'b001;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] req_addr;
    logic [31:0] skid_inst;
    logic [31:0] skid_pc;
    logic [31:0] redirect_tgt;
    logic        accept;

    function automatic logic [2:0] imm_sel(input logic [6:0] opc);
        case (opc)
            7'b0000011, 7'b0010011, 7'b1100111: imm_sel = 3'b001;
            7'b0100011:                         imm_sel = 3'b010;
            7'b1100011:                         imm_sel = 3'b011;
            7'b1101111:                         imm_sel = 3'b100;
            7'b0110111, 7'b0010111:             imm_sel = 3'b000;
            default:                            imm_sel = 3'b111;
        endcase
    endfunction

    assign redirect_tgt = redirect_pc & ~32'd3;
    assign accept       = !stall_id || !id_valid;

    // Gating with rst_n keeps the request low while reset is held.
    assign imem_req  = rst_n && (state != HOLD);
    assign imem_addr = (state == DROP) ? req_addr : pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            id_valid  <= 1'b0;
            id_inst   <= NOP_INST;
            id_pc     <= 32'd0;
            id_ImmSel <= NOP_SEL;
        end else if (redirect) begin
            pc        <= redirect_tgt;
            id_valid  <= 1'b0;
            id_inst   <= NOP_INST;
            id_ImmSel <= NOP_SEL;
            // An un-acked request must still complete at its old address.
            if (state == HOLD || imem_ack)
                state <= FETCH;
            else
                state <= DROP;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        pc <= pc + 32'd4;
                        if (accept) begin
                            id_valid  <= 1'b1;
                            id_inst   <= imem_rdata;
                            id_pc     <= pc;
                            id_ImmSel <= imm_sel(imem_rdata[6:0]);
                        end else begin
                            state <= HOLD;
                        end
                    end else if (!stall_id) begin
                        id_valid  <= 1'b0;
                        id_inst   <= NOP_INST;
                        id_ImmSel <= NOP_SEL;
                    end
                end
                HOLD: begin
                    if (!stall_id) begin
                        id_valid  <= 1'b1;
                        id_inst   <= skid_inst;
                        id_pc     <= skid_pc;
                        id_ImmSel <= imm_sel(skid_inst[6:0]);
                        state     <= FETCH;
                    end
                end
                DROP: begin
                    id_valid  <= 1'b0;
                    id_inst   <= NOP_INST;
                    id_ImmSel <= NOP_SEL;
                    if (imem_ack)
                        state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

    // Data-only registers: meaningful only in the state that consumes them.
    always_ff @(posedge clk) begin
        if (state == FETCH)
            req_addr <= pc;
        if (state == FETCH && imem_ack && !redirect && !accept) begin
            skid_inst <= imem_rdata;
            skid_pc   <= pc;
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: table-driven instruction memory and a
// scoreboard of expected {inst, pc} pairs popped as instructions reach ID.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic        stall_id = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [2:0]  id_ImmSel;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] sb[$];

    if_id_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .stall_id   (stall_id),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .id_valid   (id_valid),
        .id_inst    (id_inst),
        .id_pc      (id_pc),
        .id_ImmSel  (id_ImmSel)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'd0:   mem = 32'h0010_0093; // addi
            32'd4:   mem = 32'h0011_2023; // sw
            32'd8:   mem = 32'h0020_8463; // beq
            32'd12:  mem = 32'h0080_006f; // jal
            32'd16:  mem = 32'h0000_10b7; // lui
            default: mem = {a[31:7] ^ 25'h1a5, 7'b0110011};
        endcase
    endfunction

    function automatic logic [2:0] exp_sel(input logic [6:0] opc);
        case (opc)
            7'h03, 7'h13, 7'h67: exp_sel = 3'd1;
            7'h23:               exp_sel = 3'd2;
            7'h63:               exp_sel = 3'd3;
            7'h6f:               exp_sel = 3'd4;
            7'h37, 7'h17:        exp_sel = 3'd0;
            default:             exp_sel = 3'd7;
        endcase
    endfunction

    assign imem_rdata = mem(imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a);
        sb.push_back({mem(a), a});
    endtask

    task automatic check_id(input string tag);
        logic [63:0] e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s observed=scoreboard_empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_valid"}, {31'd0, id_valid}, 32'd1);
            check({tag, "_pc"}, id_pc, e[31:0]);
            check({tag, "_inst"}, id_inst, e[63:32]);
            check({tag, "_sel"}, {29'd0, id_ImmSel}, {29'd0, exp_sel(e[38:32])});
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        check({tag, "_addr"}, imem_addr, 32'h0000_0000);
        check({tag, "_valid"}, {31'd0, id_valid}, 32'd0);
        check({tag, "_inst"}, id_inst, 32'h0000_0013);
        check({tag, "_pc"}, id_pc, 32'd0);
        check({tag, "_sel"}, {29'd0, id_ImmSel}, 32'd1);
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_valid"}, {31'd0, id_valid}, 32'd0);
        check({tag, "_inst"}, id_inst, 32'h0000_0013);
        check({tag, "_sel"}, {29'd0, id_ImmSel}, 32'd1);
    endtask

    initial begin
        #12;
        check_reset("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'd0);

        // zero-wait stream of five instructions
        imem_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(32'(i * 4));
            tick();
            check_id("stream");
        end

        // three-cycle decode stall while the fetch at 20 is acked
        stall_id = 1'b1;
        push(32'd20);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", id_pc, 32'd16);
            check("stall_inst", id_inst, 32'h0000_10b7);
            check("stall_valid", {31'd0, id_valid}, 32'd1);
            check("stall_req", {31'd0, imem_req}, 32'd0);
        end
        stall_id = 1'b0;
        tick();
        check_id("skid");
        check("release_req", {31'd0, imem_req}, 32'd1);
        check("release_addr", imem_addr, 32'd24);
        push(32'd24);
        tick();
        check_id("after_skid");

        // redirect wins over stall with a valid instruction in ID
        redirect = 1'b1;
        redirect_pc = 32'h40;
        stall_id = 1'b1;
        tick();
        check_bubble("redir_stall");
        check("redir_stall_addr", imem_addr, 32'h40);
        redirect = 1'b0;
        stall_id = 1'b0;
        push(32'h40);
        tick();
        check_id("redir_target");

        // slow memory at 0x20, redirect to 0x103 during the wait
        redirect = 1'b1;
        redirect_pc = 32'h20;
        tick();
        check("slow_addr0", imem_addr, 32'h20);
        check_bubble("slow0");
        redirect = 1'b0;
        imem_ack = 1'b0;
        tick();
        check("slow_addr1", imem_addr, 32'h20);
        check("slow_req1", {31'd0, imem_req}, 32'd1);
        check_bubble("slow1");
        redirect = 1'b1;
        redirect_pc = 32'h103;
        tick();
        check("drop_addr", imem_addr, 32'h20);
        check("drop_req", {31'd0, imem_req}, 32'd1);
        check_bubble("drop");
        redirect = 1'b0;
        imem_ack = 1'b1;
        tick();
        check("after_drop_addr", imem_addr, 32'h100);
        check_bubble("after_drop");
        push(32'h100);
        tick();
        check_id("drop_target");

        // PC wrap at the top of the address space
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        redirect = 1'b0;
        push(32'hFFFF_FFFC);
        tick();
        check_id("wrap_top");
        push(32'd0);
        tick();
        check_id("wrap_zero");
        check("wrap_next_addr", imem_addr, 32'd4);

        // asynchronous reset in the middle of a DROP
        imem_ack = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h80;
        tick();
        check("pre_rst_drop_addr", imem_addr, 32'd4);
        redirect = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("mid_drop_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rerst_req", {31'd0, imem_req}, 32'd1);
        check("rerst_addr", imem_addr, 32'd0);
        imem_ack = 1'b1;
        push(32'd0);
        tick();
        check_id("rerst_first");
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
